alu_seq: RTL and testbench

Parametrised multi-cycle ALU for the datapath, successor to the single-cycle combinational ALU. It keeps the same 5-bit operation encoding and the HI/LO result split. It adds a sequential radix-2 Booth multiplier, an iterative signed divider, variable-distance shifts and rotates, and a start/busy/done handshake so the control unit can stall on long operations. Results are registered and held until the next completed operation.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit and alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       alu_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_low;
  logic [WIDTH-1:0] alu_high;
  logic             carry_out;
  logic             op_err;

  modport master (
    output start, alu_sel, a, b,
    input  busy, done, alu_low, alu_high, carry_out, op_err
  );

  modport slave (
    input  start, alu_sel, a, b,
    output busy, done, alu_low, alu_high, carry_out, op_err
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, Booth multiplier and,
// when ALU_SEQ_DIV_EN is defined, a restoring signed divider.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int LG = $clog2(WIDTH);

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_DIV = 5'd2,  OP_AND = 5'd3,
    OP_OR  = 5'd4,  OP_XOR = 5'd5,  OP_MUL = 5'd6,  OP_SHR = 5'd7,
    OP_SHL = 5'd8,  OP_ROR = 5'd9,  OP_ROL = 5'd10, OP_NEG = 5'd11,
    OP_NOT = 5'd12, OP_SRA = 5'd13
  } op_e;

`ifdef ALU_SEQ_DIV_EN
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;
  logic             r_sa, r_sb;
  logic [WIDTH:0]   w_dtrial, w_ddiff;
`else
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DONE} state_e;
`endif

  state_e           r_state;
  logic [LG-1:0]    r_cnt;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_mq, r_mcand;
  logic             r_q1;
  logic             r_busy, r_done, r_carry, r_err;
  logic [WIDTH-1:0] r_low, r_high;

  logic [LG-1:0]      w_n;
  logic [WIDTH:0]     w_add, w_sub;
  logic [2*WIDTH-1:0] w_rotr, w_rotl;
  logic [WIDTH-1:0]   w_low, w_high;
  logic               w_carry, w_err;
  logic [WIDTH:0]     w_bsum, w_bacc;
  logic [WIDTH-1:0]   w_bmq;
  logic               w_last;

  assign w_n    = bus.a[LG-1:0];
  assign w_add  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_sub  = {1'b0, bus.b} + {1'b0, ~bus.a} + (WIDTH+1)'(1);
  assign w_rotr = {bus.b, bus.b} >> w_n;
  assign w_rotl = {bus.b, bus.b} << w_n;
  assign w_last = (r_cnt == LG'(WIDTH-1));

  always_comb begin
    w_low   = '0;
    w_high  = '0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    case (bus.alu_sel)
      OP_ADD: {w_carry, w_low} = w_add;
      OP_SUB: {w_carry, w_low} = w_sub;
`ifdef ALU_SEQ_DIV_EN
      // Only reached for b == 0; nonzero divisors go to the iterative path.
      OP_DIV: begin
        w_low  = '1;
        w_high = bus.a;
        w_err  = 1'b1;
      end
`endif
      OP_AND: w_low = bus.a & bus.b;
      OP_OR:  w_low = bus.a | bus.b;
      OP_XOR: w_low = bus.a ^ bus.b;
      OP_MUL: w_low = '0;
      OP_SHR: w_low = bus.b >> w_n;
      OP_SHL: w_low = bus.b << w_n;
      OP_ROR: w_low = w_rotr[WIDTH-1:0];
      OP_ROL: w_low = w_rotl[2*WIDTH-1:WIDTH];
      OP_NEG: w_low = -bus.a;
      OP_NOT: w_low = {{(WIDTH-1){1'b0}}, (bus.a == '0)};
      OP_SRA: w_low = $signed(bus.b) >>> w_n;
      default: w_err = 1'b1;
    endcase
  end

  // Booth step on a WIDTH+1 accumulator so -2^(WIDTH-1) multiplicands cannot overflow.
  always_comb begin
    w_bsum = r_acc;
    case ({r_mq[0], r_q1})
      2'b01:   w_bsum = r_acc + {r_mcand[WIDTH-1], r_mcand};
      2'b10:   w_bsum = r_acc - {r_mcand[WIDTH-1], r_mcand};
      default: w_bsum = r_acc;
    endcase
    w_bacc = {w_bsum[WIDTH], w_bsum[WIDTH:1]};
    w_bmq  = {w_bsum[0], r_mq[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  assign w_dtrial = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
  assign w_ddiff  = w_dtrial - {1'b0, r_mcand};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_mcand <= '0;
      r_q1    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      r_low   <= '0;
      r_high  <= '0;
`ifdef ALU_SEQ_DIV_EN
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_cnt   <= '0;
          r_acc   <= '0;
          r_mq    <= bus.b;
          r_mcand <= bus.a;
          r_q1    <= 1'b0;
          if (bus.alu_sel == OP_MUL) begin
            r_state <= S_MUL;
            r_busy  <= 1'b1;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (bus.alu_sel == OP_DIV && bus.b != '0) begin
            r_state <= S_DIV;
            r_busy  <= 1'b1;
            r_mq    <= bus.a[WIDTH-1] ? -bus.a : bus.a;
            r_mcand <= bus.b[WIDTH-1] ? -bus.b : bus.b;
            r_sa    <= bus.a[WIDTH-1];
            r_sb    <= bus.b[WIDTH-1];
          end
`endif
          else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_low   <= w_low;
            r_high  <= w_high;
            r_carry <= w_carry;
            r_err   <= w_err;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= w_bacc;
          r_mq  <= w_bmq;
          r_q1  <= r_mq[0];
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_low   <= w_bmq;
            r_high  <= w_bacc[WIDTH-1:0];
            r_carry <= 1'b0;
            r_err   <= 1'b0;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_ddiff[WIDTH]) begin
            r_acc <= w_ddiff;
            r_mq  <= {r_mq[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_dtrial;
            r_mq  <= {r_mq[WIDTH-2:0], 1'b0};
          end
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_low   <= (r_sa ^ r_sb) ? -r_mq : r_mq;
          r_high  <= r_sa ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
          r_carry <= 1'b0;
          r_err   <= 1'b0;
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.alu_low   = r_low;
  assign bus.alu_high  = r_high;
  assign bus.carry_out = r_carry;
  assign bus.op_err    = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32); DIV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) u_if ();

  alu_seq #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one op; inj > 0 pulses an ADD start during that cycle of the op.
  task automatic run_op(input string name, input logic [4:0] sel,
                        input logic [31:0] va, input logic [31:0] vb,
                        input int exp_cyc, input logic [31:0] elow,
                        input logic [31:0] ehigh, input logic ecar,
                        input logic eerr, input int inj);
    int   cyc;
    logic busy_ok;
    @(negedge clk);
    u_if.start   = 1'b1;
    u_if.alu_sel = sel;
    u_if.a       = va;
    u_if.b       = vb;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!u_if.done && cyc < 100) begin
      if (u_if.busy !== 1'b1) busy_ok = 1'b0;
      if (inj > 0 && cyc == inj) begin
        u_if.start   = 1'b1;
        u_if.alu_sel = 5'd0;
        u_if.a       = 32'd1;
        u_if.b       = 32'd1;
      end
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      cyc++;
    end
    check({name, ".done_cycle"}, cyc, exp_cyc);
    check({name, ".busy_before_done"}, busy_ok, 1'b1);
    check({name, ".busy_at_done"}, u_if.busy, 1'b0);
    check({name, ".alu_low"}, u_if.alu_low, elow);
    check({name, ".alu_high"}, u_if.alu_high, ehigh);
    check({name, ".carry_out"}, u_if.carry_out, ecar);
    check({name, ".op_err"}, u_if.op_err, eerr);
    @(posedge clk);
    #1;
    check({name, ".done_pulse"}, u_if.done, 1'b0);
  endtask

  initial begin
    int   cyc;
    logic saw_done;
    reset        = 1'b1;
    u_if.start   = 1'b0;
    u_if.alu_sel = '0;
    u_if.a       = '0;
    u_if.b       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", u_if.busy, 1'b0);
    check("reset.done", u_if.done, 1'b0);
    check("reset.low",  u_if.alu_low, 32'h0);
    check("reset.high", u_if.alu_high, 32'h0);
    check("reset.err",  {u_if.carry_out, u_if.op_err}, 2'b00);
    reset = 1'b0;

    run_op("add_wrap", 5'd0,  32'hFFFFFFFF, 32'h00000001, 1, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    run_op("sub_borrow", 5'd1, 32'd5, 32'd3, 1, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 0);
    run_op("sub_nobor", 5'd1, 32'd3, 32'd5, 1, 32'h00000002, 32'h0, 1'b1, 1'b0, 0);
    run_op("and", 5'd3, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 32'h0, 1'b0, 1'b0, 0);
    run_op("or",  5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 0);
    run_op("xor", 5'd5, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0, 0);
    run_op("mul_neg", 5'd6, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    run_op("mul_min", 5'd6, 32'h80000000, 32'h80000000, 33, 32'h0, 32'h40000000, 1'b0, 1'b0, 0);
    run_op("shr", 5'd7,  32'd31, 32'h80000000, 1, 32'h00000001, 32'h0, 1'b0, 1'b0, 0);
    run_op("shl_mod", 5'd8, 32'd32, 32'h00000001, 1, 32'h00000001, 32'h0, 1'b0, 1'b0, 0);
    run_op("ror", 5'd9,  32'd33, 32'h00000001, 1, 32'h80000000, 32'h0, 1'b0, 1'b0, 0);
    run_op("rol", 5'd10, 32'd1,  32'h80000001, 1, 32'h00000003, 32'h0, 1'b0, 1'b0, 0);
    run_op("neg", 5'd11, 32'd1,  32'd0, 1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 0);
    run_op("not0", 5'd12, 32'd0, 32'd9, 1, 32'h00000001, 32'h0, 1'b0, 1'b0, 0);
    run_op("not5", 5'd12, 32'd5, 32'd0, 1, 32'h00000000, 32'h0, 1'b0, 1'b0, 0);
    run_op("sra", 5'd13, 32'd4, 32'h80000000, 1, 32'hF8000000, 32'h0, 1'b0, 1'b0, 0);
    run_op("illegal", 5'd14, 32'd3, 32'd4, 1, 32'h0, 32'h0, 1'b0, 1'b1, 0);
`ifdef ALU_SEQ_DIV_EN
    run_op("div_neg_a", 5'd2, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    run_op("div_neg_b", 5'd2, 32'd7, 32'hFFFFFFFE, 34, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 0);
    run_op("div_zero", 5'd2, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b1, 0);
`else
    run_op("div_off", 5'd2, 32'hFFFFFFF9, 32'd2, 1, 32'h0, 32'h0, 1'b0, 1'b1, 0);
    run_op("div_off_z", 5'd2, 32'd5, 32'd0, 1, 32'h0, 32'h0, 1'b0, 1'b1, 0);
`endif
    run_op("mul_ignore", 5'd6, 32'd6, 32'd7, 33, 32'd42, 32'h0, 1'b0, 1'b0, 5);
    run_op("neg_pre", 5'd11, 32'd1, 32'd0, 1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    u_if.start   = 1'b1;
    u_if.alu_sel = 5'd6;
    u_if.a       = 32'd6;
    u_if.b       = 32'd7;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rst_mid.busy_before", u_if.busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid.busy", u_if.busy, 1'b0);
    check("rst_mid.done", u_if.done, 1'b0);
    check("rst_mid.low",  u_if.alu_low, 32'h0);
    check("rst_mid.high", u_if.alu_high, 32'h0);
    check("rst_mid.flags", {u_if.carry_out, u_if.op_err}, 2'b00);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (u_if.done || u_if.busy) saw_done = 1'b1;
    end
    check("rst_mid.no_done", saw_done, 1'b0);
    run_op("add_after_rst", 5'd0, 32'd2, 32'd3, 1, 32'd5, 32'h0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
